// File: rtl/server_op0_out.sv
// rtl/server_op0_out.sv - op0 egress drain: packet FIFO to registered AXI4-Stream master with inter-packet gap (optional stats via SERVER_OP0_OUT_STATS_EN)
module server_op0_out #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int IFG_CYCLES           = 2
) (
   input  logic                                axis_aclk,
   input  logic                                axis_resetn,
   input  logic                                i_pkt_fifo_empty,
   output logic                                o_pkt_fifo_rd_en,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      i_tdata_fifo,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     i_tuser_fifo,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    i_tkeep_fifo,
   input  logic                                i_tlast_fifo,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]      o_op0_out_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    o_op0_out_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]     o_op0_out_tuser,
   output logic                                o_op0_out_tvalid,
   output logic                                o_op0_out_tlast,
   input  logic                                i_op0_out_tready
`ifdef SERVER_OP0_OUT_STATS_EN
   ,
   output logic [31:0]                         o_pkt_cnt,
   output logic [47:0]                         o_byte_cnt
`endif
);

   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state;
   logic [GW-1:0] gap_cnt;
   logic          last_loaded;
   logic          load;
   logic          hs;

   // Pop the FIFO head into the output register when the packet is still open and the register is free or draining.
   assign load = axis_resetn
              && ((state == IDLE) || ((state == SEND) && !last_loaded))
              && !i_pkt_fifo_empty
              && (!o_op0_out_tvalid || i_op0_out_tready);
   assign hs               = o_op0_out_tvalid && i_op0_out_tready;
   assign o_pkt_fifo_rd_en = load;

   // Framing FSM and output register stage.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state            <= IDLE;
         gap_cnt          <= '0;
         last_loaded      <= 1'b0;
         o_op0_out_tdata  <= '0;
         o_op0_out_tkeep  <= '0;
         o_op0_out_tuser  <= '0;
         o_op0_out_tlast  <= 1'b0;
         o_op0_out_tvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  state <= SEND;
               end
            end
            SEND: begin
               // last_loaded blocks loads, so a tlast handshake never coincides with a load
               if (hs && o_op0_out_tlast) begin
                  last_loaded <= 1'b0;
                  if (IFG_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (load) begin
            o_op0_out_tdata  <= i_tdata_fifo;
            o_op0_out_tkeep  <= i_tkeep_fifo;
            o_op0_out_tuser  <= i_tuser_fifo;
            o_op0_out_tlast  <= i_tlast_fifo;
            o_op0_out_tvalid <= 1'b1;
            last_loaded      <= i_tlast_fifo;
         end else if (hs) begin
            o_op0_out_tvalid <= 1'b0;
         end
      end
   end

`ifdef SERVER_OP0_OUT_STATS_EN
   logic [47:0] beat_bytes;

   assign beat_bytes = 48'($countones(o_op0_out_tkeep));

   // Packet and byte counters, both advanced on accepted beats and left to wrap.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         o_pkt_cnt  <= '0;
         o_byte_cnt <= '0;
      end else if (hs) begin
         o_byte_cnt <= o_byte_cnt + beat_bytes;
         if (o_op0_out_tlast) begin
            o_pkt_cnt <= o_pkt_cnt + 32'd1;
         end
      end
   end
`endif

   logic unused_kw;
   assign unused_kw = (KW == 0);

endmodule
